// File: rtl/approx_mul_pipe_pkg.sv
// Shared constants for the approximate multiplier pipeline: mode encoding
// and the parameter limits checked at elaboration.
package approx_mul_pipe_pkg;

   localparam logic MODE_EXACT  = 1'b0;
   localparam logic MODE_APPROX = 1'b1;

   localparam int DATA_WIDTH_MIN = 1;
   localparam int OUT_WIDTH_MIN  = 1;
   localparam int STAGES_MIN     = 1;
   localparam int STAGES_MAX     = 4;
   localparam int DROP_BITS_MIN  = 0;

   function automatic int max_int(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

endpackage

// File: rtl/mul_pipe_slice.sv
// One valid/hold register slice of the multiplier pipeline. Loads when told to
// advance; data is only captured for valid entries so the payload stays quiet.
module mul_pipe_slice
   import approx_mul_pipe_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter bit RESET_DATA = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             adv_i,
   input  logic             valid_i,
   input  logic             mode_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   output logic             mode_o,
   output logic [WIDTH-1:0] data_o
);

   logic             valid_q, valid_d;
   logic             mode_q, mode_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             load;

   assign load    = adv_i & valid_i;
   assign valid_d = adv_i ? valid_i : valid_q;
   assign mode_d  = load ? mode_i : mode_q;
   assign data_d  = load ? data_i : data_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Only the output slice needs a defined payload out of reset.
   if (RESET_DATA) begin : g_rst_data
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            mode_q <= MODE_EXACT;
            data_q <= '0;
         end else begin
            mode_q <= mode_d;
            data_q <= data_d;
         end
      end
   end else begin : g_raw_data
      always_ff @(posedge clock) begin
         mode_q <= mode_d;
         data_q <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign mode_o  = mode_q;
   assign data_o  = data_q;

endmodule

// File: rtl/approx_mul_pipe.sv
// Pipelined unsigned multiplier with per-transaction exact/approximate mode.
// Approximate mode drops operand LSBs before the multiply and restores scale after.
module approx_mul_pipe
   import approx_mul_pipe_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int OUT_WIDTH  = 16,
   parameter int DROP_BITS  = 1,
   parameter int STAGES     = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] io_inputs_1,
   input  logic [DATA_WIDTH-1:0] io_inputs_0,
   input  logic                  io_mode,
   input  logic                  io_in_valid,
   output logic                  io_in_ready,
   output logic [OUT_WIDTH-1:0]  io_outs_0,
   output logic                  io_out_valid,
   input  logic                  io_out_ready
);

   localparam int PW = 2 * DATA_WIDTH;
   localparam int SW = max_int(PW, OUT_WIDTH);

   if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
      $error("approx_mul_pipe: STAGES must be within 1..4");
   end
   if (DROP_BITS < DROP_BITS_MIN || DROP_BITS >= DATA_WIDTH) begin : g_bad_drop
      $error("approx_mul_pipe: DROP_BITS must be within 0..DATA_WIDTH-1");
   end
   if (DATA_WIDTH < DATA_WIDTH_MIN || OUT_WIDTH < OUT_WIDTH_MIN) begin : g_bad_width
      $error("approx_mul_pipe: DATA_WIDTH and OUT_WIDTH must be positive");
   end

   function automatic logic [PW-1:0] f_pre(input logic [DATA_WIDTH-1:0] a,
                                           input logic [DATA_WIDTH-1:0] b,
                                           input logic                  mode);
      logic [DATA_WIDTH-1:0] a_s, b_s;
      a_s = (mode == MODE_APPROX) ? (a >> DROP_BITS) : a;
      b_s = (mode == MODE_APPROX) ? (b >> DROP_BITS) : b;
      return {a_s, b_s};
   endfunction

   function automatic logic [PW-1:0] f_mul(input logic [PW-1:0] ops);
      logic [PW-1:0] ea, eb;
      ea = PW'(ops[PW-1:DATA_WIDTH]);
      eb = PW'(ops[DATA_WIDTH-1:0]);
      return ea * eb;
   endfunction

   // Scale restore cannot overflow PW bits: the shifted operands leave 2*DROP_BITS headroom.
   function automatic logic [SW-1:0] f_fin(input logic [PW-1:0] prod, input logic mode);
      logic [SW-1:0] ext;
      ext = SW'(prod);
      return (mode == MODE_APPROX) ? (ext << (2 * DROP_BITS)) : ext;
   endfunction

   logic          v_q [STAGES];
   logic          m_q [STAGES];
   logic [SW-1:0] d_q [STAGES];
   logic          adv [STAGES];

   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         adv[k] = 1'b0;
      end
      adv[STAGES-1] = !v_q[STAGES-1] || io_out_ready;
      for (int k = STAGES - 2; k >= 0; k--) begin
         adv[k] = !v_q[k] || adv[k+1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic          v_in;
      logic          m_in;
      logic [SW-1:0] d_in;

      if (k == 0) begin : g_head
         assign v_in = io_in_valid;
         assign m_in = io_mode;
         if (STAGES == 1) begin : g_single
            assign d_in = f_fin(f_mul(f_pre(io_inputs_1, io_inputs_0, io_mode)), io_mode);
         end else begin : g_split
            assign d_in = SW'(f_pre(io_inputs_1, io_inputs_0, io_mode));
         end
      end else begin : g_body
         assign v_in = v_q[k-1];
         assign m_in = m_q[k-1];
         if (k == 1 && STAGES == 2) begin : g_mul_fin
            assign d_in = f_fin(f_mul(d_q[0][PW-1:0]), m_q[0]);
         end else if (k == 1) begin : g_mul
            assign d_in = SW'(f_mul(d_q[0][PW-1:0]));
         end else if (k == STAGES - 1) begin : g_fin
            assign d_in = f_fin(d_q[k-1][PW-1:0], m_q[k-1]);
         end else begin : g_pass
            assign d_in = d_q[k-1];
         end
      end

      mul_pipe_slice #(
         .WIDTH      (SW),
         .RESET_DATA (k == STAGES - 1)
      ) u_slice (
         .clock   (clock),
         .reset   (reset),
         .adv_i   (adv[k]),
         .valid_i (v_in),
         .mode_i  (m_in),
         .data_i  (d_in),
         .valid_o (v_q[k]),
         .mode_o  (m_q[k]),
         .data_o  (d_q[k])
      );
   end

   assign io_in_ready  = adv[0];
   assign io_out_valid = v_q[STAGES-1];
   assign io_outs_0    = d_q[STAGES-1][OUT_WIDTH-1:0];

   logic unused_tail;
   assign unused_tail = ^{1'b0, m_q[STAGES-1], d_q[STAGES-1]};

endmodule
